// File: rtl/ulpi_reg_access_ctrl.sv
// ULPI PHY register access sequencer: two requesters, round-robin, DIR abort/retry.
// Optional NXT/DIR wait timeout is built when ULPI_REG_TIMEOUT_EN is defined.
module ulpi_reg_access_ctrl #(
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned NXT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [5:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [5:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TXCMD,
    S_WDATA,
    S_STP,
    S_RD_TURN,
    S_RD_DATA,
    S_RD_END,
    S_ABORT_WAIT
  } state_t;

  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  retry_q, retry_d;
  logic        rr_q, rr_d;
  logic        gnt;
  logic        drive;
  logic        abort;
  logic        tmo_hit;
  logic        tmo_fire;

`ifdef ULPI_REG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(NXT_TIMEOUT - 1);
  logic [15:0] tmo_q;
  logic        tmo_run;

  assign tmo_run = (state_q == S_TXCMD) ||
                   (state_q == S_WDATA) ||
                   (state_q == S_RD_TURN);
  assign tmo_hit = tmo_run && (tmo_q == TMO_LAST);

  // Length of the current wait; restarts whenever the state moves
  always_ff @(posedge clk) begin
    if (rst || !tmo_run || (state_d != state_q))
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + 16'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (NXT_TIMEOUT == 0);
  assign tmo_hit    = 1'b0;
`endif

  // State register, latched request, retry count and arbiter pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      retry_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      retry_q <= retry_d;
      rr_q    <= rr_d;
    end
  end

  // Next state, grant/latching, bus drive and response outputs
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    retry_d       = retry_q;
    rr_d          = rr_q;
    drive         = 1'b0;
    abort         = 1'b0;
    tmo_fire      = 1'b0;
    ulpi_data_out = 8'h00;
    ulpi_stp      = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp_valid     = 1'b0;
    rsp_err       = 1'b0;
    rsp_rdata     = 8'h00;
    gnt = (req0_valid && req1_valid) ? rr_q : req1_valid;

    unique case (state_q)
      S_IDLE: begin
        if (!rst && !ulpi_dir && (req0_valid || req1_valid)) begin
          req0_ready = ~gnt;
          req1_ready = gnt;
          id_d       = gnt;
          we_d       = gnt ? req1_we    : req0_we;
          addr_d     = gnt ? req1_addr  : req0_addr;
          wdata_d    = gnt ? req1_wdata : req0_wdata;
          retry_d    = '0;
          rr_d       = ~gnt;
          state_d    = S_TXCMD;
        end
      end
      S_TXCMD: begin
        drive         = 1'b1;
        ulpi_data_out = {1'b1, ~we_q, addr_q};
        if (ulpi_dir)
          abort = 1'b1;
        else if (ulpi_nxt)
          state_d = we_q ? S_WDATA : S_RD_TURN;
        else if (tmo_hit)
          tmo_fire = 1'b1;
      end
      S_WDATA: begin
        drive         = 1'b1;
        ulpi_data_out = wdata_q;
        if (ulpi_dir)
          abort = 1'b1;
        else if (ulpi_nxt)
          state_d = S_STP;
        else if (tmo_hit)
          tmo_fire = 1'b1;
      end
      S_STP: begin
        drive     = 1'b1;
        ulpi_stp  = 1'b1;
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_RD_TURN: begin
        if (ulpi_dir)
          state_d = S_RD_DATA;
        else if (tmo_hit)
          tmo_fire = 1'b1;
      end
      S_RD_DATA: begin
        rsp_valid = 1'b1;
        rsp_rdata = ulpi_data_in;
        state_d   = S_RD_END;
      end
      S_RD_END: begin
        if (!ulpi_dir)
          state_d = S_IDLE;
      end
      S_ABORT_WAIT: begin
        if (!ulpi_dir)
          state_d = S_TXCMD;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      if (retry_q == RETRY_MAX) begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = S_IDLE;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = S_ABORT_WAIT;
      end
    end

    if (tmo_fire) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
      state_d   = S_IDLE;
    end
  end

  assign rsp_id       = rsp_valid & id_q;
  assign ulpi_data_oe = drive & ~ulpi_dir & ~tmo_fire;

endmodule

// File: tb/tb_ulpi_reg_access_ctrl.sv
// Self-checking bench for ulpi_reg_access_ctrl: the bench plays the PHY and
// both requesters, with expectations from a transaction-level model.
module tb_ulpi_reg_access_ctrl;

  localparam int unsigned MAXR = 3;
  localparam int unsigned TMO  = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       dir, nxt;
  logic [7:0] din;
  logic       v0, we0, v1, we1;
  logic [5:0] a0, a1;
  logic [7:0] w0, w1;
  logic [7:0] dout;
  logic       oe, stp, rdy0, rdy1;
  logic       rv, rid, rerr;
  logic [7:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  bit last_gnt = 1'b1;

  always #5 clk = ~clk;

  ulpi_reg_access_ctrl #(
    .MAX_RETRY(MAXR),
    .NXT_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ulpi_dir(dir),
    .ulpi_nxt(nxt),
    .ulpi_data_in(din),
    .ulpi_data_out(dout),
    .ulpi_data_oe(oe),
    .ulpi_stp(stp),
    .req0_valid(v0),
    .req0_we(we0),
    .req0_addr(a0),
    .req0_wdata(w0),
    .req0_ready(rdy0),
    .req1_valid(v1),
    .req1_we(we1),
    .req1_addr(a1),
    .req1_wdata(w1),
    .req1_ready(rdy1),
    .rsp_valid(rv),
    .rsp_id(rid),
    .rsp_rdata(rdata),
    .rsp_err(rerr)
  );

  function automatic logic [7:0] txcmd(bit we, logic [5:0] a);
    return (we ? 8'h80 : 8'hC0) + {2'b00, a};
  endfunction

  task automatic quiet();
    v0 = 0; v1 = 0; nxt = 0; dir = 0;
    din = 8'($urandom);
  endtask

  task automatic present(bit id, bit we, logic [5:0] a, logic [7:0] d);
    if (id) begin
      v1 = 1; we1 = we; a1 = a; w1 = d;
    end else begin
      v0 = 1; we0 = we; a0 = a; w0 = d;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; quiet();
    v0 = 1'($urandom); v1 = 1'($urandom);
    we0 = 0; we1 = 0; a0 = 0; a1 = 0; w0 = 0; w1 = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({dout, oe, stp, rdy0, rdy1, rv, rid, rdata, rerr} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outs=%h want 0",
               {dout, oe, stp, rdy0, rdy1, rv, rid, rdata, rerr});
    end
    @(negedge clk);
    rst = 0; quiet();
    #1;
    n_tests++;
    if ({dout, oe, stp, rdy0, rdy1, rv, rid, rdata, rerr} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: outs=%h want 0",
               {dout, oe, stp, rdy0, rdy1, rv, rid, rdata, rerr});
    end
    last_gnt = 1'b1;
  endtask

  task automatic test_write(int n);
    for (int i = 0; i < n; i++) begin
      bit id;
      logic [5:0] a;
      logic [7:0] d;
      int d1, d2;
      if (i == 0) begin
        id = 0; a = 6'h04; d = 8'h49; d1 = 0; d2 = 0;
      end else begin
        id = 1'($urandom); a = 6'($urandom); d = 8'($urandom);
        d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3);
      end
      @(negedge clk);
      quiet(); present(id, 1, a, d);
      #1;
      n_tests++;
      if (rdy0 !== !id || rdy1 !== id) begin
        n_fail++;
        $display("FAIL wr_ready: rdy0=%b rdy1=%b want id %0d", rdy0, rdy1, id);
      end
      last_gnt = id;
      for (int k = 0; k <= d1; k++) begin
        @(negedge clk);
        v0 = 0; v1 = 0; nxt = (k == d1);
        #1;
        n_tests++;
        if (dout !== txcmd(1, a) || oe !== 1 || stp !== 0 || rv !== 0) begin
          n_fail++;
          $display("FAIL wr_txcmd: dout=%h oe=%b stp=%b rv=%b want %h 1 0 0",
                   dout, oe, stp, rv, txcmd(1, a));
        end
      end
      for (int k = 0; k <= d2; k++) begin
        @(negedge clk);
        nxt = (k == d2);
        #1;
        n_tests++;
        if (dout !== d || oe !== 1 || stp !== 0 || rv !== 0) begin
          n_fail++;
          $display("FAIL wr_data: dout=%h oe=%b stp=%b rv=%b want %h 1 0 0",
                   dout, oe, stp, rv, d);
        end
      end
      @(negedge clk);
      nxt = 0;
      #1;
      n_tests++;
      if (stp !== 1 || rv !== 1 || rid !== id || rerr !== 0 ||
          rdata !== 0 || oe !== 1 || dout !== 0) begin
        n_fail++;
        $display("FAIL wr_stp: stp=%b rv=%b id=%b err=%b rd=%h oe=%b do=%h want 1 1 %b 0 0 1 0",
                 stp, rv, rid, rerr, rdata, oe, dout, id);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (stp !== 0 || oe !== 0 || rv !== 0) begin
        n_fail++;
        $display("FAIL wr_idle: stp=%b oe=%b rv=%b want 0 0 0", stp, oe, rv);
      end
    end
  endtask

  task automatic test_read();
    for (int i = 0; i < 8; i++) begin
      bit id;
      logic [5:0] a;
      logic [7:0] pd;
      int d1, dt, de;
      if (i == 0) begin
        id = 1; a = 6'h0A; pd = 8'h5C; d1 = 0; dt = 0; de = 1;
      end else begin
        id = 1'($urandom); a = 6'($urandom); pd = 8'($urandom);
        d1 = $urandom_range(0, 3); dt = $urandom_range(0, 3);
        de = $urandom_range(0, 3);
      end
      @(negedge clk);
      quiet(); present(id, 0, a, 8'($urandom));
      #1;
      n_tests++;
      if (rdy0 !== !id || rdy1 !== id) begin
        n_fail++;
        $display("FAIL rd_ready: rdy0=%b rdy1=%b want id %0d", rdy0, rdy1, id);
      end
      last_gnt = id;
      for (int k = 0; k <= d1; k++) begin
        @(negedge clk);
        v0 = 0; v1 = 0; nxt = (k == d1);
        #1;
        n_tests++;
        if (dout !== txcmd(0, a) || oe !== 1 || rv !== 0) begin
          n_fail++;
          $display("FAIL rd_txcmd: dout=%h oe=%b rv=%b want %h 1 0",
                   dout, oe, rv, txcmd(0, a));
        end
      end
      for (int k = 0; k <= dt; k++) begin
        @(negedge clk);
        nxt = 0; dir = (k == dt); din = 8'($urandom);
        #1;
        n_tests++;
        if (oe !== 0 || dout !== 0 || rv !== 0) begin
          n_fail++;
          $display("FAIL rd_turn: oe=%b dout=%h rv=%b want 0 0 0", oe, dout, rv);
        end
      end
      @(negedge clk);
      dir = 1; din = pd;
      #1;
      n_tests++;
      if (rv !== 1 || rdata !== pd || rid !== id || rerr !== 0 || oe !== 0) begin
        n_fail++;
        $display("FAIL rd_data: rv=%b rd=%h id=%b err=%b oe=%b want 1 %h %b 0 0",
                 rv, rdata, rid, rerr, oe, pd, id);
      end
      for (int k = 0; k <= de; k++) begin
        @(negedge clk);
        dir = (k < de); din = 8'($urandom);
        #1;
        n_tests++;
        if (rv !== 0 || oe !== 0) begin
          n_fail++;
          $display("FAIL rd_end: rv=%b oe=%b want 0 0", rv, oe);
        end
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (rv !== 0 || oe !== 0 || stp !== 0) begin
        n_fail++;
        $display("FAIL rd_idle: rv=%b oe=%b stp=%b want 0", rv, oe, stp);
      end
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    rst = 1; quiet();
    @(negedge clk);
    rst = 0;
    last_gnt = 1'b1;
    present(0, 1, 6'($urandom), 8'($urandom));
    present(1, 1, 6'($urandom), 8'($urandom));
    nxt = 1;
    for (int r = 0; r < 4; r++) begin
      bit exp;
      logic [5:0] ea;
      logic [7:0] ed;
      exp = ~last_gnt;
      ea = exp ? a1 : a0;
      ed = exp ? w1 : w0;
      #1;
      n_tests++;
      if (rdy0 !== !exp || rdy1 !== exp) begin
        n_fail++;
        $display("FAIL rr_grant round %0d: rdy0=%b rdy1=%b want id %0d",
                 r, rdy0, rdy1, exp);
      end
      last_gnt = exp;
      @(negedge clk);
      present(exp, 1, 6'($urandom), 8'($urandom));
      #1;
      n_tests++;
      if (dout !== txcmd(1, ea) || oe !== 1) begin
        n_fail++;
        $display("FAIL rr_txcmd: dout=%h oe=%b want %h 1", dout, oe, txcmd(1, ea));
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (dout !== ed) begin
        n_fail++;
        $display("FAIL rr_data: dout=%h want %h", dout, ed);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (stp !== 1 || rv !== 1 || rid !== exp || rdy0 !== 0 || rdy1 !== 0) begin
        n_fail++;
        $display("FAIL rr_stp: stp=%b rv=%b id=%b rdy=%b%b want 1 1 %b 00",
                 stp, rv, rid, rdy0, rdy1, exp);
      end
      @(negedge clk);
    end
    quiet();
    #1;
    n_tests++;
    if (rdy0 !== 0 || rdy1 !== 0) begin
      n_fail++;
      $display("FAIL rr_last_grant: rdy=%b%b want 00", rdy0, rdy1);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 4; i++) begin
      bit id;
      logic [5:0] a;
      logic [7:0] d;
      int h;
      id = 1'($urandom); a = 6'($urandom); d = 8'($urandom);
      h = $urandom_range(0, 3);
      @(negedge clk);
      quiet(); present(id, 1, a, d);
      #1;
      n_tests++;
      if (rdy0 !== !id || rdy1 !== id) begin
        n_fail++;
        $display("FAIL ab_ready: rdy=%b%b want id %0d", rdy0, rdy1, id);
      end
      last_gnt = id;
      @(negedge clk);
      v0 = 0; v1 = 0; nxt = 1;
      @(negedge clk);
      nxt = 0; dir = 1;
      #1;
      n_tests++;
      if (oe !== 0 || stp !== 0 || rv !== 0) begin
        n_fail++;
        $display("FAIL ab_dir_rise: oe=%b stp=%b rv=%b want 0 0 0", oe, stp, rv);
      end
      for (int k = 0; k <= h; k++) begin
        @(negedge clk);
        dir = (k < h);
        #1;
        n_tests++;
        if (oe !== 0 || dout !== 0 || rv !== 0) begin
          n_fail++;
          $display("FAIL ab_wait: oe=%b dout=%h rv=%b want 0 0 0", oe, dout, rv);
        end
      end
      @(negedge clk);
      dir = 0; nxt = 1;
      #1;
      n_tests++;
      if (dout !== txcmd(1, a) || oe !== 1) begin
        n_fail++;
        $display("FAIL ab_resend: dout=%h oe=%b want %h 1", dout, oe, txcmd(1, a));
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (dout !== d || oe !== 1) begin
        n_fail++;
        $display("FAIL ab_redata: dout=%h oe=%b want %h 1", dout, oe, d);
      end
      @(negedge clk);
      nxt = 0;
      #1;
      n_tests++;
      if (stp !== 1 || rv !== 1 || rid !== id || rerr !== 0) begin
        n_fail++;
        $display("FAIL ab_done: stp=%b rv=%b id=%b err=%b want 1 1 %b 0",
                 stp, rv, rid, rerr, id);
      end
    end
  endtask

  task automatic test_retry_exhaust();
    for (int i = 0; i < 3; i++) begin
      bit id, we;
      logic [5:0] a;
      id = 1'($urandom); we = 1'($urandom); a = 6'($urandom);
      @(negedge clk);
      quiet(); present(id, we, a, 8'($urandom));
      #1;
      last_gnt = id;
      for (int att = 0; att <= int'(MAXR); att++) begin
        bit inw, fin;
        inw = we && 1'($urandom);
        fin = (att == int'(MAXR));
        @(negedge clk);
        v0 = 0; v1 = 0;
        if (inw) begin
          nxt = 1; dir = 0;
          #1;
          n_tests++;
          if (dout !== txcmd(we, a) || oe !== 1) begin
            n_fail++;
            $display("FAIL ex_txcmd: dout=%h oe=%b want %h 1", dout, oe, txcmd(we, a));
          end
          @(negedge clk);
        end
        nxt = 1'($urandom); dir = 1;
        #1;
        n_tests++;
        if (oe !== 0 || rv !== fin || rerr !== fin || (fin && rid !== id)) begin
          n_fail++;
          $display("FAIL ex_abort att %0d: oe=%b rv=%b err=%b id=%b want 0 %b %b %b",
                   att, oe, rv, rerr, rid, fin, fin, id);
        end
        if (!fin) begin
          @(negedge clk);
          dir = 0; nxt = 0;
          #1;
          n_tests++;
          if (oe !== 0 || rv !== 0) begin
            n_fail++;
            $display("FAIL ex_wait: oe=%b rv=%b want 0 0", oe, rv);
          end
        end
      end
      @(negedge clk);
      dir = 0; nxt = 0;
      #1;
      n_tests++;
      if (oe !== 0 || stp !== 0 || rv !== 0) begin
        n_fail++;
        $display("FAIL ex_idle: oe=%b stp=%b rv=%b want 0 0 0", oe, stp, rv);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    quiet(); present(1, 0, 6'($urandom), 8'h00);
    #1;
    last_gnt = 1;
    @(negedge clk);
    v1 = 0; nxt = 1;
    @(negedge clk);
    nxt = 0; rst = 1;
    @(negedge clk);
    rst = 0; din = 8'($urandom);
    #1;
    n_tests++;
    if ({dout, oe, stp, rdy0, rdy1, rv, rid, rdata, rerr} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs: outs=%h want 0",
               {dout, oe, stp, rdy0, rdy1, rv, rid, rdata, rerr});
    end
    last_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dir = 1'($urandom); din = 8'($urandom);
      #1;
      n_tests++;
      if (rv !== 0 || stp !== 0 || oe !== 0) begin
        n_fail++;
        $display("FAIL rstmid_quiet: rv=%b stp=%b oe=%b want 0 0 0", rv, stp, oe);
      end
    end
    @(negedge clk);
    quiet(); present(0, 1, 6'($urandom), 8'($urandom));
    present(1, 1, 6'($urandom), 8'($urandom));
    #1;
    n_tests++;
    if (rdy0 !== 1 || rdy1 !== 0) begin
      n_fail++;
      $display("FAIL rstmid_ptr: rdy=%b%b want 10", rdy0, rdy1);
    end
    last_gnt = 0;
    @(negedge clk);
    v0 = 0; v1 = 0; nxt = 1;
    @(negedge clk);
    @(negedge clk);
    nxt = 0;
    @(negedge clk);
  endtask

`ifdef ULPI_REG_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk);
    quiet(); present(0, 1, 6'($urandom), 8'($urandom));
    #1;
    last_gnt = 0;
    for (int k = 0; k < int'(TMO); k++) begin
      @(negedge clk);
      v0 = 0; nxt = 0;
      #1;
      n_tests++;
      if (k < int'(TMO) - 1) begin
        if (rv !== 0 || oe !== 1) begin
          n_fail++;
          $display("FAIL tmo_wait %0d: rv=%b oe=%b want 0 1", k, rv, oe);
        end
      end else if (rv !== 1 || rerr !== 1 || oe !== 0 || stp !== 0) begin
        n_fail++;
        $display("FAIL tmo_fire: rv=%b err=%b oe=%b stp=%b want 1 1 0 0",
                 rv, rerr, oe, stp);
      end
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (rv !== 0 || stp !== 0 || oe !== 0) begin
      n_fail++;
      $display("FAIL tmo_idle: rv=%b stp=%b oe=%b want 0", rv, stp, oe);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; quiet();
    we0 = 0; we1 = 0; a0 = 0; a1 = 0; w0 = 0; w1 = 0;
    test_reset();
    test_write(8);
    test_read();
    test_round_robin();
    test_abort();
    test_retry_exhaust();
    test_reset_mid();
`ifdef ULPI_REG_TIMEOUT_EN
    test_timeout();
`endif
    test_write(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
